multicycle_adder_subtracter_module: RTL

MULTICYCLE_ADDER_SUBTRACTER_MODULE -- requirements
Module: multicycle_adder_subtracter_module

---
 rtl/multicycle_adder_subtracter_module.sv | 118 +++++++++++
 1 files changed

// File: rtl/multicycle_adder_subtracter_module.sv
// Two's-complement add/subtract processed CHUNK bits per cycle, with optional saturation.
// Latency: start at edge 0 -> done pulse after edge N (N = WIDTH/CHUNK), ready again after edge N+1.
// Backpressure: start is only honoured while ready=1; requests during RUN/DONE are dropped, not queued.
module multicycle_adder_subtracter_module #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             sat,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v,
    output logic             zero
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             carry_q, sat_q;
    logic [IDXW-1:0]  idx_q;
    logic             ready_q, done_q, cout_q, v_q, zero_q;
    logic [WIDTH-1:0] sum_q;

    logic [CHUNK-1:0] a_chk, b_chk;
    logic [CHUNK:0]   chk_sum;
    logic [WIDTH-1:0] res_d, final_d;
    logic             msb_cin, v_d, last;

    always_comb begin
        a_chk   = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_chk   = b_q[int'(idx_q)*CHUNK +: CHUNK];
        chk_sum = {1'b0, a_chk} + {1'b0, b_chk} + {{CHUNK{1'b0}}, carry_q};
        res_d   = res_q;
        res_d[int'(idx_q)*CHUNK +: CHUNK] = chk_sum[CHUNK-1:0];
        // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last chunk.
        msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ res_d[WIDTH-1];
        v_d     = msb_cin ^ chk_sum[CHUNK];
        if (sat_q && v_d) begin
            final_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_d = res_d;
        end
        last = (idx_q == IDXW'(N-1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b ^ {WIDTH{s}};
                        sat_q   <= sat;
                        carry_q <= s;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= chk_sum[CHUNK];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        sum_q   <= final_d;
                        cout_q  <= chk_sum[CHUNK];
                        v_q     <= v_d;
                        zero_q  <= (final_d == '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign v     = v_q;
    assign zero  = zero_q;

endmodule
